// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotating column drive, 2-FF row synchroniser,
// full-frame debounce and a registered one-hot / binary decode of the accepted frame.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_onehot,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        multi_key
);

    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE_SCANS);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [3:0]       row_hit;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       col_next;
    logic [15:0]      raw;
    logic [15:0]      raw_next;
    logic [15:0]      last_frame;
    logic [3:0]       stable_cnt;
    logic [3:0]       stable_next;
    logic             sample;
    logic             frame_done;
    logic             accept;
    logic [4:0]       pop;
    logic [3:0]       idx;

    // Rows are asynchronous to clk; only row_sync is ever looked at.
    // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign row_hit    = ~row_sync;
    assign sample     = (div_cnt == DIV_LAST);
    assign frame_done = sample && (col_idx == 2'd3);
    assign col_next   = col_idx + 2'd1;

    // raw with the current column overwritten; on the last column this is the candidate frame.
    // NOTE: combinational blocks assign a default first so no latch can be inferred.
    always_comb begin
        raw_next = raw;
        for (int r = 0; r < 4; r++) begin
            raw_next[{2'(r), col_idx}] = row_hit[r];
        end
    end

    always_comb begin
        stable_next = 4'd1;
        if (raw_next == last_frame) begin
            stable_next = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
        end
    end

    assign accept = frame_done && (stable_next == STABLE_MAX);

    always_comb begin
        pop = 5'd0;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (raw_next[i]) begin
                pop = pop + 5'd1;
                idx = 4'(i);
            end
        end
    end

    // Column slot timing: settle for SCAN_DIV-1 cycles, sample on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            col_out <= 4'b1110;
            raw     <= 16'h0000;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= col_next;
            col_out <= ~(4'b0001 << col_next);
            raw     <= raw_next;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_frame <= 16'h0000;
            stable_cnt <= 4'd0;
        end else if (frame_done) begin
            last_frame <= raw_next;
            stable_cnt <= stable_next;
        end
    end

    // Re-accepting an identical frame rewrites the same values, so outputs hold steady.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_onehot <= 16'h0000;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
            multi_key  <= 1'b0;
        end else if (accept) begin
            if (pop == 5'd0) begin
                key_onehot <= 16'h0000;
                key_valid  <= 1'b0;
                multi_key  <= 1'b0;
            end else if (pop == 5'd1) begin
                key_onehot <= raw_next;
                key_valid  <= 1'b1;
                key_code   <= idx;
                multi_key  <= 1'b0;
            end else begin
                key_onehot <= 16'h0000;
                key_valid  <= 1'b0;
                multi_key  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a cycle-indexed behavioural model of the scanned keypad
// checked every cycle, directed scenarios with literal expectations, then random presses.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int FRAME          = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_onehot;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        multi_key;

    logic [15:0] keys = 16'h0000;  // physically pressed keys, bit row*4+col

    int errors = 0;
    int checks = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .multi_key  (multi_key)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row is pulled low when a pressed key on it sits in a driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Edge k after reset release is in column (k/SCAN_DIV)%4; the sample taken on the last
    // edge of a slot sees the keys as they were two edges earlier (synchroniser delay).
    int          k = 0;
    logic [15:0] hist[$];
    logic [15:0] m_frame = 16'h0000;
    logic [15:0] m_last = 16'h0000;
    int          m_stable = 0;
    logic [3:0]  exp_col = 4'b1110;
    logic [15:0] exp_onehot = 16'h0000;
    logic        exp_valid = 1'b0;
    logic        exp_multi = 1'b0;
    logic [3:0]  exp_code = 4'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                k = 0;
                hist.delete();
                m_frame = 16'h0000;
                m_last = 16'h0000;
                m_stable = 0;
                exp_col = 4'b1110;
                exp_onehot = 16'h0000;
                exp_valid = 1'b0;
                exp_multi = 1'b0;
                exp_code = 4'd0;
            end else begin
                hist.push_back(keys);
                if (k % SCAN_DIV == SCAN_DIV - 1) begin
                    int c;
                    int cs;
                    logic [15:0] seen;
                    c = (k / SCAN_DIV) % 4;
                    seen = (k >= 2) ? hist[k-2] : 16'h0000;
                    cs = (k >= 2) ? ((k - 2) / SCAN_DIV) % 4 : 0;
                    for (int r = 0; r < 4; r++) m_frame[r*4+c] = seen[r*4+cs];
                    if (c == 3) begin
                        if (m_frame == m_last) begin
                            if (m_stable < DEBOUNCE_SCANS) m_stable++;
                        end else begin
                            m_last = m_frame;
                            m_stable = 1;
                        end
                        if (m_stable == DEBOUNCE_SCANS) begin
                            int n;
                            n = $countones(m_frame);
                            if (n == 0) begin
                                exp_onehot = 16'h0000;
                                exp_valid = 1'b0;
                                exp_multi = 1'b0;
                            end else if (n == 1) begin
                                exp_onehot = m_frame;
                                exp_valid = 1'b1;
                                exp_multi = 1'b0;
                                for (int i = 0; i < 16; i++) if (m_frame[i]) exp_code = 4'(i);
                            end else begin
                                exp_onehot = 16'h0000;
                                exp_valid = 1'b0;
                                exp_multi = 1'b1;
                            end
                        end
                    end
                end
                k++;
                exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst)
            check("reset_outputs", {6'd0, col_out, key_onehot, key_valid, multi_key, key_code},
                  {6'd0, 4'b1110, 16'h0000, 1'b0, 1'b0, 4'd0});
        else
            check("cycle_outputs", {6'd0, col_out, key_onehot, key_valid, multi_key, key_code},
                  {6'd0, exp_col, exp_onehot, exp_valid, exp_multi, exp_code});
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_k_reached", k, target);
    endtask

    task automatic next_frame();
        wait_k(((k / FRAME) + 1) * FRAME);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (cycles) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0;
        rst = 1'b0;
        keys = 16'h0000;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // 1: idle scan, column rotation
        wait_k(3);  check("t1_col_slot0", col_out, 4'b1110);
        wait_k(4);  check("t1_col_slot1", col_out, 4'b1101);
        wait_k(8);  check("t1_col_slot2", col_out, 4'b1011);
        wait_k(12); check("t1_col_slot3", col_out, 4'b0111);
        wait_k(16); check("t1_col_wrap", col_out, 4'b1110);
        wait_k(10 * FRAME);
        check("t1_idle_outputs", {key_onehot, key_valid, multi_key}, {16'h0000, 1'b0, 1'b0});

        // 2: key row1/col2 press and release
        keys = 16'h0040;
        wait_k(k + 4 * FRAME);
        check("t2_onehot", key_onehot, 16'h0040);
        check("t2_code", key_code, 4'd6);
        check("t2_valid", key_valid, 1'b1);
        keys = 16'h0000;
        wait_k(k + 4 * FRAME);
        check("t2_release", {key_onehot, key_valid}, {16'h0000, 1'b0});
        check("t2_code_held", key_code, 4'd6);

        // 3: bounce on key 0, then a clean hold; exact acceptance timing
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            next_frame();
            check("t3_bounce_quiet", {key_onehot, key_valid}, {16'h0000, 1'b0});
        end
        keys = 16'h0001;
        f0 = k;
        wait_k(f0 + 3 * FRAME - 1);
        check("t3_not_yet", key_valid, 1'b0);
        wait_k(f0 + 3 * FRAME);
        check("t3_accept", {key_onehot, key_valid}, {16'h0001, 1'b1});

        // 4: two keys -> multi_key; drop one -> valid again
        keys = 16'h0021;
        wait_k(k + 4 * FRAME);
        check("t4_multi", {key_onehot, key_valid, multi_key}, {16'h0000, 1'b0, 1'b1});
        check("t4_code_held", key_code, 4'd0);
        keys = 16'h0001;
        wait_k(k + 4 * FRAME);
        check("t4_single", {key_onehot, key_valid, multi_key}, {16'h0001, 1'b1, 1'b0});

        // 5: reset mid-slot while key 15 is valid
        keys = 16'h8000;
        wait_k(k + 4 * FRAME);
        check("t5_valid", {key_valid, key_code}, {1'b1, 4'd15});
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("t5_async_clear", {col_out, key_onehot, key_valid, multi_key, key_code},
                 {4'b1110, 16'h0000, 1'b0, 1'b0, 4'd0});
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        wait_k(3 * FRAME - 1);
        check("t5_no_stale", key_valid, 1'b0);
        wait_k(3 * FRAME);
        check("t5_reaccept", {key_onehot, key_valid, key_code}, {16'h8000, 1'b1, 4'd15});

        // 6: key 3 then straight to key 12 mid-frame
        next_frame();
        keys = 16'h0008;
        wait_k(k + 4 * FRAME);
        check("t6_first", {key_onehot, key_code}, {16'h0008, 4'd3});
        wait_k(k + 7);
        keys = 16'h1000;
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(negedge clk);
            check("t6_valid_held", key_valid, 1'b1);
        end
        check("t6_second", {key_onehot, key_code}, {16'h1000, 4'd12});

        // Random presses, chords, bounce and occasional resets against the model
        for (int it = 0; it < 40; it++) begin
            int mode;
            int a;
            int b;
            int hold;
            mode = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            hold = $urandom_range(1, 5) * FRAME + $urandom_range(0, FRAME - 1);
            case (mode)
                0: keys = 16'h0000;
                1: keys = 16'h0001 << a;
                2: keys = (16'h0001 << a) | (16'h0001 << b);
                default: begin
                    for (int i = 0; i < hold; i++) begin
                        @(negedge clk);
                        keys = ($urandom_range(0, 1) == 1) ? (16'h0001 << a) : 16'h0000;
                    end
                end
            endcase
            repeat (hold) @(negedge clk);
            if ($urandom_range(0, 9) == 0) pulse_reset(2);
        end
        keys = 16'h0000;
        repeat (5 * FRAME) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
